mem_ctrl: RTL

- MEM stage of the 5-stage pipeline. It sits between the EX/MEM latch and the MEM/WB latch.
- Non-memory ops: passes wd/wreg/wdata through unchanged.
- Load/store ops: runs a req/ack transaction on the data bus, stalls the pipeline until the transaction completes, then formats load data for writeback.

---
 rtl/mem_ctrl.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl -- MEM stage of the 5-stage pipeline (between EX/MEM and MEM/WB).
//
// Non-memory ops pass wd/wreg/wdata straight through. Loads and stores run a
// single req/ack transaction on the data bus, stall the pipeline until it
// completes (or times out), then present formatted load data for writeback.
// Lane mapping is big-endian: byte offset 0 lives in bits [31:24].
//
// Ports
//   clk, rst                 pipeline clock, synchronous active-high reset
//   aluop_i, wd_i, wreg_i,   instruction fields from the EX/MEM latch
//   wdata_i, mem_addr_i,
//   mem_data_i
//   wd_o, wreg_o, wdata_o    writeback fields to the MEM/WB latch
//   stallreq_o               stall request to pipeline control
//   misalign_o, bus_err_o    one-cycle exception flags
//   bus_req_o, bus_we_o,     registered data-bus request
//   bus_addr_o, bus_sel_o,
//   bus_wdata_o
//   bus_rdata_i, bus_ack_i   data-bus response (rdata valid with ack)
// -----------------------------------------------------------------------------
module mem_ctrl #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  aluop_i,
   input  logic [4:0]  wd_i,
   input  logic        wreg_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_data_i,
   output logic [4:0]  wd_o,
   output logic        wreg_o,
   output logic [31:0] wdata_o,
   output logic        stallreq_o,
   output logic        misalign_o,
   output logic        bus_err_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_sel_o,
   output logic [31:0] bus_wdata_o,
   input  logic [31:0] bus_rdata_i,
   input  logic        bus_ack_i
);

   localparam logic [7:0] OP_LB  = 8'hE0;
   localparam logic [7:0] OP_LH  = 8'hE1;
   localparam logic [7:0] OP_LW  = 8'hE3;
   localparam logic [7:0] OP_LBU = 8'hE4;
   localparam logic [7:0] OP_LHU = 8'hE5;
   localparam logic [7:0] OP_SB  = 8'hE8;
   localparam logic [7:0] OP_SH  = 8'hE9;
   localparam logic [7:0] OP_SW  = 8'hEB;

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q;
   logic [7:0]      op_q;      // op of the access in flight, for load formatting
   logic [1:0]      off_q;     // byte offset of the access in flight
   logic [31:0]     rdata_q;
   logic            err_q;

   logic            is_load, is_store, is_mem, aligned, start;
   logic            timeout_hit;
   logic [3:0]      sel_d;
   logic [31:0]     bwdata_d;

   function automatic logic is_load_op(input logic [7:0] op);
      return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
   endfunction

   function automatic logic is_store_op(input logic [7:0] op);
      return op inside {OP_SB, OP_SH, OP_SW};
   endfunction

   // Extract the addressed lane(s) from the bus word and extend to 32 bits.
   function automatic logic [31:0] fmt_load(input logic [7:0]  op,
                                            input logic [1:0]  off,
                                            input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'd0:    b = d[31:24];
         2'd1:    b = d[23:16];
         2'd2:    b = d[15:8];
         default: b = d[7:0];
      endcase
      h = off[1] ? d[15:0] : d[31:16];
      case (op)
         OP_LB:   r = {{24{b[7]}}, b};
         OP_LBU:  r = {24'h0, b};
         OP_LH:   r = {{16{h[15]}}, h};
         OP_LHU:  r = {16'h0, h};
         default: r = d;
      endcase
      return r;
   endfunction

   // Decode of the incoming instruction: access class, alignment, lanes, data.
   always_comb begin
      is_load  = is_load_op(aluop_i);
      is_store = is_store_op(aluop_i);
      is_mem   = is_load | is_store;
      case (aluop_i)
         OP_LH, OP_LHU, OP_SH: aligned = ~mem_addr_i[0];
         OP_LW, OP_SW:         aligned = (mem_addr_i[1:0] == 2'b00);
         default:              aligned = 1'b1;
      endcase
      case (aluop_i)
         OP_LB, OP_LBU, OP_SB: begin
            case (mem_addr_i[1:0])
               2'd0:    sel_d = 4'b1000;
               2'd1:    sel_d = 4'b0100;
               2'd2:    sel_d = 4'b0010;
               default: sel_d = 4'b0001;
            endcase
            bwdata_d = {4{mem_data_i[7:0]}};
         end
         OP_LH, OP_LHU, OP_SH: begin
            sel_d    = mem_addr_i[1] ? 4'b0011 : 4'b1100;
            bwdata_d = {2{mem_data_i[15:0]}};
         end
         default: begin
            sel_d    = 4'b1111;
            bwdata_d = mem_data_i;
         end
      endcase
   end

   assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

   // Next-state and pipeline-facing outputs.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // a variable unassigned, which would otherwise infer a latch.
      state_d    = state_q;
      start      = 1'b0;
      wd_o       = wd_i;
      wreg_o     = wreg_i;
      wdata_o    = wdata_i;
      stallreq_o = 1'b0;
      misalign_o = 1'b0;
      bus_err_o  = 1'b0;
      case (state_q)
         IDLE: begin
            if (is_mem) begin
               wreg_o = 1'b0;
               if (aligned) begin
                  stallreq_o = 1'b1;
                  start      = 1'b1;
                  state_d    = BUSY;
               end else begin
                  misalign_o = 1'b1;
               end
            end
         end
         BUSY: begin
            stallreq_o = 1'b1;
            wreg_o     = 1'b0;
            // Ack is checked first so an ack on the timeout cycle wins.
            if (bus_ack_i || timeout_hit) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
            if (err_q) begin
               wreg_o    = 1'b0;
               bus_err_o = 1'b1;
            end else if (is_load_op(op_q)) begin
               wdata_o = rdata_q;
            end else begin
               wreg_o = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      if (rst) begin
         wd_o       = 5'd0;
         wreg_o     = 1'b0;
         wdata_o    = 32'd0;
         stallreq_o = 1'b0;
         misalign_o = 1'b0;
         bus_err_o  = 1'b0;
      end
   end

   // State, bus registers and transaction bookkeeping.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         bus_req_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= 32'd0;
         bus_sel_o   <= 4'd0;
         bus_wdata_o <= 32'd0;
         cnt_q       <= '0;
         op_q        <= 8'd0;
         off_q       <= 2'd0;
         rdata_q     <= 32'd0;
         err_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (start) begin
                  bus_req_o   <= 1'b1;
                  bus_we_o    <= is_store;
                  bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
                  bus_sel_o   <= sel_d;
                  bus_wdata_o <= bwdata_d;
                  cnt_q       <= '0;
                  op_q        <= aluop_i;
                  off_q       <= mem_addr_i[1:0];
                  err_q       <= 1'b0;
               end
            end
            BUSY: begin
               cnt_q <= cnt_q + 1'b1;
               if (bus_ack_i) begin
                  rdata_q   <= fmt_load(op_q, off_q, bus_rdata_i);
                  bus_req_o <= 1'b0;
               end else if (timeout_hit) begin
                  bus_req_o <= 1'b0;
                  err_q     <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
